alu_arbiter: RTL
================

# alu_arbiter

Round-robin scheduler that shares the single multi-base ALU router among NUM_REQ independent requesters. It accepts one operation at a time over per-requester valid/ready handshakes and drives the router's operation, operand and base-select inputs. It holds them stable until the selected ALU signals done or a timeout expires, then returns the result with the requester ID over a valid/ready response channel.

## Interface
- NUM_REQ, 4, number of requesters; must be ≥2. IDW = $clog2(NUM_REQ).
- TIMEOUT, 64, maximum WAIT-state cycles before abort; must be ≥2. The counter is $clog2(TIMEOUT+1) bits.

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low: 0 resets immediately, release is synchronous to clk.
- req_valid  in  NUM_REQ  requester i has an operation pending.
- req_ready  out  NUM_REQ  one-hot grant; a handshake completes when req_valid[i] & req_ready[i].
- req_operation  in  4*NUM_REQ  slice i = operation code of requester i.
- req_operand_a, req_operand_b  in  32*NUM_REQ  slice i = operands.
- req_base  in  2*NUM_REQ  0=base2, 1=base10, 2=base12, 3=illegal.
- rt_operation  out  4  to router operation.
- rt_operand_a, rt_operand_b  out  32  to router operands.
- rt_base_select  out  2  to router base_select.
- rt_result  in  32  router result.
- rt_done  in  1  router done.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW  index of the requester served.
- resp_result  out  32  captured result; 0 on error.
- resp_error  out  1  1 = timeout or illegal base.
- busy  out  1  1 whenever state ≠ IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from pointer ptr upward modulo NUM_REQ. req_ready for the granted requester is combinational: state==IDLE & grant.
  - On handshake, capture op, operands, base and ID into registers.
  - If base=3, go to RESP with resp_error=1 and resp_result=0. Otherwise go to ISSUE.
  - With no valid requester, stay in IDLE. All req_ready=0 outside IDLE.
- ISSUE: drive rt_* from the captured registers for exactly 1 cycle. rt_done is ignored in this cycle so a stale done from the previous operation is not taken. Clear the timeout counter and go to WAIT.
- WAIT:
  - rt_* stay held. When rt_done=1, capture rt_result into resp_result, set resp_error=0 and go to RESP.
  - Otherwise increment the timeout counter. When the counter equals TIMEOUT-1 and rt_done=0, set resp_result=0, resp_error=1 and go to RESP.
  - rt_done on that same final cycle counts as success; done has priority over timeout.
- RESP:
  - resp_valid=1 and resp_* are stable until resp_ready=1.
  - On the response handshake, set ptr = (served ID + 1) mod NUM_REQ and go to IDLE.
  - req_valid changes during RESP have no effect.
- rt_* are driven to 0 in IDLE and RESP (operation 0, operands 0, base_select 0).
- Only the granted requester's slices are ever sampled.
- Requesters must hold req_* stable while req_valid=1. Dropping req_valid before grant is legal and that request is simply not served.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rt_*=0, resp_valid=0, resp_id=0, resp_result=0, resp_error=0, busy=0.
- Assertion of reset in any state aborts the operation with no response and forces the reset values on the next evaluation, without waiting for a clock edge.
- Latency, with the request handshake in cycle 0:
  - ISSUE is cycle 1, WAIT starts in cycle 2.
  - rt_done first seen in cycle k (k≥2) gives resp_valid in cycle k+1. The minimum is cycle 3.
- Timeout with no done: resp_valid in cycle 2+TIMEOUT.
- Illegal base: resp_valid in cycle 1, and rt_* never leave 0.
- A response handshake in cycle n returns to IDLE in cycle n+1, where the next grant may complete, giving a 1-cycle gap.
- Fairness: a continuously valid requester is granted within NUM_REQ operations.

## Test plan
- Single request: requester 2 sends op 0, a=5, b=7, base=1; router model asserts done 3 cycles after ISSUE with result 12. Required: rt_base_select=1 held through WAIT; resp_id=2, resp_result=12, resp_error=0; resp_valid 4 cycles after ISSUE.
- Round robin: all 4 requesters continuously valid, resp_ready tied 1. Required: grant order 0,1,2,3,0; no requester is granted twice before all others are served.
- Backpressure: resp_ready held 0 for 10 cycles. Required: resp_valid and resp_* stable throughout; req_ready stays 0; next grant occurs only after the resp handshake.
- Timeout, TIMEOUT=8, rt_done never asserted. Required: resp_valid exactly 10 cycles after the request handshake, resp_error=1, resp_result=0. A second run with done on the final WAIT cycle must give resp_error=0.
- Illegal base=3 from requester 1. Required: resp_valid the next cycle, resp_error=1; rt_* remain 0.
- Reset mid-WAIT: pull reset low asynchronously. Required: all outputs take reset values immediately; after release, requester 0 is granted first (ptr=0).

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one multi-base ALU router among NUM_REQ requesters.
// Holds the router inputs until done or timeout and returns the tagged result.
module alu_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_operation,
  input  logic [32*NUM_REQ-1:0]   req_operand_a,
  input  logic [32*NUM_REQ-1:0]   req_operand_b,
  input  logic [2*NUM_REQ-1:0]    req_base,
  output logic [3:0]              rt_operation,
  output logic [31:0]             rt_operand_a,
  output logic [31:0]             rt_operand_b,
  output logic [1:0]              rt_base_select,
  input  logic [31:0]             rt_result,
  input  logic                    rt_done,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [31:0]             resp_result,
  output logic                    resp_error,
  output logic                    busy
);

  localparam int unsigned OPW = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 2;
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BASE_ILLEGAL = BW'(3);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [OPW-1:0] operation;
    logic [DW-1:0]  operand_a;
    logic [DW-1:0]  operand_b;
    logic [BW-1:0]  base;
  } op_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  op_t            req_sel;
  op_t            op_q;
  logic [CW-1:0]  cnt_q;

  logic load_req, load_ok, load_err, cnt_clr, cnt_inc, ptr_adv;

  // Index (base + off) modulo NUM_REQ; off never exceeds NUM_REQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base_i,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base_i) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // First valid requester searching upward from ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[wrap_idx(ptr_q, i)]) begin
        grant_any = 1'b1;
        grant_id  = wrap_idx(ptr_q, i);
      end
    end
  end

  always_comb begin
    req_sel.operation = req_operation[grant_id*OPW +: OPW];
    req_sel.operand_a = req_operand_a[grant_id*DW +: DW];
    req_sel.operand_b = req_operand_b[grant_id*DW +: DW];
    req_sel.base      = req_base[grant_id*BW +: BW];
  end

  // Grant is only offered in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && grant_any && reset && (grant_id == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    load_ok  = 1'b0;
    load_err = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    ptr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          load_req = 1'b1;
          if (req_sel.base == BASE_ILLEGAL) begin
            load_err = 1'b1;
            state_d  = RESP;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_clr = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // done wins over timeout on the final cycle
        if (rt_done) begin
          load_ok = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          load_err = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          ptr_adv = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Captured request, response payload, timeout counter and rotation pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= '0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_error  <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= '0;
    end else begin
      if (load_req) begin
        op_q    <= req_sel;
        resp_id <= grant_id;
      end
      if (load_ok) begin
        resp_result <= rt_result;
        resp_error  <= 1'b0;
      end else if (load_err) begin
        resp_result <= '0;
        resp_error  <= 1'b1;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CW'(1);
      if (ptr_adv) ptr_q <= wrap_idx(resp_id, 1);
    end
  end

  logic drive_rt;
  assign drive_rt       = (state_q == ISSUE) || (state_q == WAIT);
  assign rt_operation   = drive_rt ? op_q.operation : '0;
  assign rt_operand_a   = drive_rt ? op_q.operand_a : '0;
  assign rt_operand_b   = drive_rt ? op_q.operand_b : '0;
  assign rt_base_select = drive_rt ? op_q.base      : '0;

  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);

endmodule
